pc_unit: RTL

Parametrised fetch-stage program-counter unit, successor to the single-register fetch PC. Holds the current fetch address and selects the next one from trap, redirect, stall-hold, optional BTB prediction or sequential increment. Adds a boot bubble, halt/resume control, a fetch-valid qualifier and misalignment reporting. Sits at the head of IF and drives the instruction-memory address and the IF/ID pipeline register.

---
 rtl/pc_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with boot bubble, halt/resume,
// trap/redirect steering with target alignment, and an optional
// direct-mapped BTB enabled by defining the macro PC_BTB_EN.
module pc_unit #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_VEC = '0,
  parameter int unsigned         INC       = 4,
  parameter int unsigned         BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_F,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            pred_taken_o,
  output logic            misalign_o
);

  localparam int unsigned     ALIGN      = $clog2(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            pred_q, pred_d;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] trap_tgt, redir_tgt;
  logic            trap_mis, redir_mis;
  logic            btb_hit;
  logic [XLEN-1:0] btb_tgt;

  assign pc_plus   = pc_q + XLEN'(INC);
  assign trap_tgt  = trap_pc & ~ALIGN_MASK;
  assign redir_tgt = redirect_pc & ~ALIGN_MASK;
  assign trap_mis  = (trap_pc & ALIGN_MASK) != '0;
  assign redir_mis = (redirect_pc & ALIGN_MASK) != '0;

`ifdef PC_BTB_EN
  localparam int unsigned IDXW = $clog2(BTB_DEPTH);
  localparam int unsigned TAGW = XLEN - ALIGN - IDXW;

  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TAGW-1:0]      btb_tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt_q [BTB_DEPTH];
  logic [IDXW-1:0]      rd_idx, wr_idx;
  logic                 unused_upd_low;

  assign rd_idx         = pc_q[ALIGN +: IDXW];
  assign wr_idx         = btb_upd_pc[ALIGN +: IDXW];
  assign btb_hit        = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[XLEN-1 -: TAGW]);
  assign btb_tgt        = btb_tgt_q[rd_idx];
  assign unused_upd_low = ^btb_upd_pc[ALIGN-1:0];

  // BTB valid bits, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid_q <= '0;
    end else if (btb_upd_valid) begin
      btb_valid_q[wr_idx] <= 1'b1;
    end
  end

  // BTB tag/target storage; reads this cycle see the pre-write contents
  always_ff @(posedge clk) begin
    if (btb_upd_valid) begin
      btb_tag_q[wr_idx] <= btb_upd_pc[XLEN-1 -: TAGW];
      btb_tgt_q[wr_idx] <= btb_upd_target & ~ALIGN_MASK;
    end
  end
`else
  logic unused_btb;

  assign btb_hit    = 1'b0;
  assign btb_tgt    = '0;
  assign unused_btb = ^{btb_upd_valid, btb_upd_pc, btb_upd_target};
`endif

  // State, PC and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      pred_q     <= pred_d;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    pred_d     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (trap_valid) begin
          pc_d       = trap_tgt;
          misalign_d = trap_mis;
        end else if (redirect_valid) begin
          pc_d       = redir_tgt;
          misalign_d = redir_mis;
        end else if (stall_F) begin
          pc_d = pc_q;
        end else if (btb_hit) begin
          pc_d   = btb_tgt;
          pred_d = 1'b1;
        end else begin
          pc_d = pc_plus;
        end
        if (halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (trap_valid) begin
          pc_d       = trap_tgt;
          misalign_d = trap_mis;
          state_d    = ST_RUN;
        end else begin
          if (redirect_valid) begin
            pc_d       = redir_tgt;
            misalign_d = redir_mis;
          end
          if (resume_req) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign pc_o         = pc_q;
  assign pc_plus_o    = pc_plus;
  assign pc_valid_o   = (state_q == ST_RUN) && !stall_F;
  assign pred_taken_o = pred_q;
  assign misalign_o   = misalign_q;

endmodule
